// File: rtl/disp_source_sched_if.sv
// Source/display bundle for disp_source_sched: raw buttons, four candidate
// values with valid flags in; selected value, index, mode and blank out.
interface disp_source_sched_if;
  logic       btnNext;
  logic       btnMode;
  logic [5:0] src0;
  logic [5:0] src1;
  logic [5:0] src2;
  logic [5:0] src3;
  logic [3:0] srcValid;
  logic [5:0] sixBit;
  logic [1:0] srcSel;
  logic       autoMode;
  logic       blank;

  modport master (
    output btnNext, btnMode, src0, src1, src2, src3, srcValid,
    input  sixBit, srcSel, autoMode, blank
  );

  modport slave (
    input  btnNext, btnMode, src0, src1, src2, src3, srcValid,
    output sixBit, srcSel, autoMode, blank
  );
endinterface

// File: rtl/disp_source_sched.sv
// Shares one 6-bit display path between four sources, stepped by a debounced
// button (MANUAL) or a dwell timer (AUTO). Define DISP_SNAPSHOT_EN to freeze
// the shown value while the selection is stable.
//
// state  | meaning
// MANUAL | selection moves only on a next press or an invalid current source
// AUTO   | selection also rotates every DWELL_CYCLES clocks
module disp_source_sched #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 100000000
) (
  input logic            clock,
  input logic            rst,
  disp_source_sched_if.slave bus
);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  logic [1:0]      btn_raw, sync1, sync2, deb, press;
  logic [DB_W-1:0] db_cnt [2];
  logic            next_p, mode_p;

  assign btn_raw = {bus.btnMode, bus.btnNext};
  assign next_p  = press[0];
  assign mode_p  = press[1];

  // Bit 0 = next button, bit 1 = mode button; pulse only on accepted 0->1.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          deb[i]    <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  state_t          state;
  logic [DW_W-1:0] dwell;
  logic [1:0]      sel_q;
  logic [5:0]      six_q;
  logic            auto_q, blank_q;

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] step, next_sel;
  logic [5:0] sel_val;
  logic       none_valid, hold, dwell_hit, advance;

  // Rotate the valid mask so bit 0 is the slot after the current one, then
  // take the lowest set bit; an all-but-current-invalid mask lands on step 3.
  always_comb begin
    dbl      = {bus.srcValid, bus.srcValid} >> ({1'b0, sel_q} + 3'd1);
    rot      = dbl[3:0];
    step     = 2'd3;
    if (rot[0])      step = 2'd0;
    else if (rot[1]) step = 2'd1;
    else if (rot[2]) step = 2'd2;
    next_sel = sel_q + 2'd1 + step;

    case (sel_q)
      2'd0:    sel_val = bus.src0;
      2'd1:    sel_val = bus.src1;
      2'd2:    sel_val = bus.src2;
      default: sel_val = bus.src3;
    endcase

    none_valid = (bus.srcValid == 4'd0);
    hold       = none_valid | blank_q;
    dwell_hit  = (state == AUTO) && (dwell == DW_LAST);
    advance    = !hold && (next_p || dwell_hit || !bus.srcValid[sel_q]);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= MANUAL;
      auto_q <= 1'b0;
      dwell  <= '0;
      sel_q  <= '0;
    end else begin
      if (advance) sel_q <= next_sel;
      if (mode_p) begin
        state  <= (state == MANUAL) ? AUTO : MANUAL;
        auto_q <= (state == MANUAL);
        dwell  <= '0;
      end else if (state == AUTO && !hold) begin
        if (next_p || dwell_hit) dwell <= '0;
        else                     dwell <= dwell + DW_W'(1);
      end
    end
  end

`ifdef DISP_SNAPSHOT_EN
  logic moved;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      six_q   <= '0;
      blank_q <= 1'b1;
`ifdef DISP_SNAPSHOT_EN
      moved   <= 1'b0;
`endif
    end else begin
      blank_q <= none_valid;
`ifdef DISP_SNAPSHOT_EN
      moved <= advance && (next_sel != sel_q);
      if (none_valid)            six_q <= '0;
      else if (moved || blank_q) six_q <= sel_val;
`else
      six_q <= none_valid ? 6'd0 : sel_val;
`endif
    end
  end

  assign bus.sixBit   = six_q;
  assign bus.srcSel   = sel_q;
  assign bus.autoMode = auto_q;
  assign bus.blank    = blank_q;
endmodule
